// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: widths, block geometry,
// controller state encoding, owner encoding and the fill address helper.
package cache_fill_arbiter_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int BLK_WORDS = 8;
    localparam int IDX_W     = 3;

    // Clears the byte offset within a 16-byte block.
    localparam logic [ADDR_W-1:0] BLK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte address of word idx inside the block starting at base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return base + {{(ADDR_W-IDX_W-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word counter for one block transfer: clear has priority over enable,
// tc flags the last word of the block.
module fill_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    // Count words; wraps naturally from the last word back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == IDX_W'(BLK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single main memory between the I-cache and D-cache.
// Stores go out as single write cycles; misses become 8-word block fills
// whose words are returned to the owning cache with their index.
//
// Handshake: ic_miss, dc_miss and dc_wr_req are levels that the requester
// holds until it sees its one-cycle completion pulse (ic_fill_done,
// dc_fill_done, dc_wr_ack) and drops in the following cycle; the pulse is
// raised while the controller is in a state that cannot grant, so a
// finished request is never granted a second time.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_miss_addr,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_miss_addr,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              ic_fill_we,
    output logic              dc_fill_we,
    output logic              ic_fill_done,
    output logic              dc_fill_done,
    output logic              dc_wr_ack,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic [ADDR_W-1:0] base;

    logic [IDX_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic [IDX_W-1:0]  next_issue;
    logic              issue_tc;
    logic              recv_tc;
    logic              cnt_clr;
    logic              issue_en;
    logic              recv_en;
    logic              grant_d;
    logic [ADDR_W-1:0] miss_base;

    // With both misses pending the cache that was not served last wins.
    assign grant_d    = dc_miss && (!ic_miss || (last_owner == OWN_I));
    assign miss_base  = (grant_d ? dc_miss_addr : ic_miss_addr) & BLK_MASK;
    assign next_issue = issue_cnt + 1'b1;

    // The issue counter advances on every read strobe of a fill, the receive
    // counter on every returned word; both restart whenever the block is idle.
    assign cnt_clr  = (state == ST_IDLE);
    assign issue_en = (state == ST_FILL) && mem_enable;
    assign recv_en  = (state == ST_FILL) && mem_data_valid;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (issue_en),
        .cnt   (issue_cnt),
        .tc    (issue_tc)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (recv_en),
        .cnt   (recv_cnt),
        .tc    (recv_tc)
    );

    assign dbg_state = state;

    // Controller FSM; every output is a flop updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner        <= OWN_I;
            last_owner   <= OWN_I;
            base         <= '0;
            mem_enable   <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            fill_data    <= '0;
            fill_idx     <= '0;
            ic_fill_we   <= 1'b0;
            dc_fill_we   <= 1'b0;
            ic_fill_done <= 1'b0;
            dc_fill_done <= 1'b0;
            dc_wr_ack    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ic_fill_we   <= 1'b0;
            dc_fill_we   <= 1'b0;
            ic_fill_done <= 1'b0;
            dc_fill_done <= 1'b0;
            dc_wr_ack    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dc_wr_req) begin
                        state        <= ST_WRITE;
                        busy         <= 1'b1;
                        mem_enable   <= 1'b1;
                        mem_wr       <= 1'b1;
                        mem_addr     <= dc_wr_addr;
                        mem_data_out <= dc_wr_data;
                        dc_wr_ack    <= 1'b1;
                    end else if (ic_miss || dc_miss) begin
                        state      <= ST_FILL;
                        busy       <= 1'b1;
                        owner      <= grant_d ? OWN_D : OWN_I;
                        base       <= miss_base;
                        mem_enable <= 1'b1;
                        mem_wr     <= 1'b0;
                        mem_addr   <= miss_base;
                    end
                end
                ST_WRITE: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    mem_enable   <= 1'b0;
                    mem_wr       <= 1'b0;
                    mem_addr     <= '0;
                    mem_data_out <= '0;
                end
                ST_FILL: begin
                    if (mem_enable) begin
                        if (issue_tc) begin
                            mem_enable <= 1'b0;
                            mem_addr   <= '0;
                        end else begin
                            mem_addr <= word_addr(base, next_issue);
                        end
                    end
                    if (mem_data_valid) begin
                        fill_data  <= mem_data_in;
                        fill_idx   <= recv_cnt;
                        ic_fill_we <= (owner == OWN_I);
                        dc_fill_we <= (owner == OWN_D);
                        if (recv_tc) begin
                            state        <= ST_DONE;
                            ic_fill_done <= (owner == OWN_I);
                            dc_fill_done <= (owner == OWN_D);
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    last_owner <= owner;
                    mem_enable <= 1'b0;
                    mem_addr   <= '0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                end
            endcase
        end
    end

endmodule
